// File: rtl/adder_word_scheduler.sv
// Shares one N-bit adder between two requesters, adding N*WORDS-bit operands a word per cycle.
// Define ADDER_SCHED_PERF_EN to add the saturating op_count response counter.
module n_bit_adder #(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};

endmodule

module adder_word_scheduler #(
  parameter int N     = 8,
  parameter int WORDS = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [N*WORDS-1:0] req0_a,
  input  logic [N*WORDS-1:0] req0_b,
  input  logic               req0_cin,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic [N*WORDS-1:0] req1_a,
  input  logic [N*WORDS-1:0] req1_b,
  input  logic               req1_cin,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic               resp_id,
  output logic [N*WORDS-1:0] resp_sum,
  output logic               resp_cout,
  output logic               busy
`ifdef ADDER_SCHED_PERF_EN
  ,
  output logic [15:0]        op_count
`endif
);

  localparam int W  = N * WORDS;
  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t         state;
  logic           last_grant;
  logic           grant;
  logic           accept;
  logic [IW-1:0]  idx;
  logic           carry;
  logic [W-1:0]   op_a;
  logic [W-1:0]   op_b;
  logic [N-1:0]   word_a;
  logic [N-1:0]   word_b;
  logic [N-1:0]   add_sum;
  logic           add_cout;
  int             base;

  // A lone requester always wins; a tie alternates against the last winner.
  always_comb begin
    grant = ~last_grant;
    unique case (1'b1)
      (req0_valid && !req1_valid): grant = 1'b0;
      (req1_valid && !req0_valid): grant = 1'b1;
      default: ;
    endcase
  end

  assign req0_ready = (state == IDLE) && !grant && reset;
  assign req1_ready = (state == IDLE) && grant && reset;
  assign accept     = (req0_valid && req0_ready)
                    || (req1_valid && req1_ready);
  assign busy       = (state != IDLE);

  assign base   = int'(idx) * N;
  assign word_a = op_a[base +: N];
  assign word_b = op_b[base +: N];

  n_bit_adder #(.N(N)) u_add (
    .a    (word_a),
    .b    (word_b),
    .cin  (carry),
    .sum  (add_sum),
    .cout (add_cout)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      idx        <= '0;
      carry      <= 1'b0;
      op_a       <= '0;
      op_b       <= '0;
      resp_valid <= 1'b0;
      resp_id    <= 1'b0;
      resp_sum   <= '0;
      resp_cout  <= 1'b0;
`ifdef ADDER_SCHED_PERF_EN
      op_count   <= '0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            op_a    <= grant ? req1_a : req0_a;
            op_b    <= grant ? req1_b : req0_b;
            carry   <= grant ? req1_cin : req0_cin;
            resp_id <= grant;
            idx     <= '0;
            state   <= RUN;
          end
        end
        RUN: begin
          resp_sum[base +: N] <= add_sum;
          carry               <= add_cout;
          idx                 <= idx + 1'b1;
          if (idx == IW'(WORDS - 1)) begin
            resp_cout  <= add_cout;
            resp_valid <= 1'b1;
            state      <= DONE;
          end
        end
        DONE: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            last_grant <= resp_id;
            state      <= IDLE;
`ifdef ADDER_SCHED_PERF_EN
            if (op_count != 16'hFFFF)
              op_count <= op_count + 16'd1;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_word_scheduler.sv
// Directed and random checks for adder_word_scheduler at N=8, WORDS=4.
module tb_adder_word_scheduler;

  localparam int N     = 8;
  localparam int WORDS = 4;
  localparam int W     = N * WORDS;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         req0_valid = 1'b0;
  logic         req0_ready;
  logic [W-1:0] req0_a = '0;
  logic [W-1:0] req0_b = '0;
  logic         req0_cin = 1'b0;
  logic         req1_valid = 1'b0;
  logic         req1_ready;
  logic [W-1:0] req1_a = '0;
  logic [W-1:0] req1_b = '0;
  logic         req1_cin = 1'b0;
  logic         resp_valid;
  logic         resp_ready = 1'b0;
  logic         resp_id;
  logic [W-1:0] resp_sum;
  logic         resp_cout;
  logic         busy;
`ifdef ADDER_SCHED_PERF_EN
  logic [15:0]  op_count;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  adder_word_scheduler #(.N(N), .WORDS(WORDS)) dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_cin   (req0_cin),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_cin   (req1_cin),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_sum   (resp_sum),
    .resp_cout  (resp_cout),
    .busy       (busy)
`ifdef ADDER_SCHED_PERF_EN
    ,
    .op_count   (op_count)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_resp(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (resp_valid) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    resp_ready = 1'b0;
    tick();
    tick();
    checks++;
    if ({resp_valid, busy, resp_cout, resp_id} !== 4'b0) begin
      errors++;
      $display("FAIL reset_flags got v%b b%b c%b id%b want 0",
               resp_valid, busy, resp_cout, resp_id);
    end
    checks++;
    if (resp_sum !== '0) begin
      errors++;
      $display("FAIL reset_sum got %h want 0", resp_sum);
    end
    checks++;
    if ({req0_ready, req1_ready} !== 2'b00) begin
      errors++;
      $display("FAIL reset_ready got %b%b want 00",
               req0_ready, req1_ready);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    reset = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle busy got %b want 0", busy);
    end
  endtask

  task automatic test_single();
    int lat;
    resp_ready = 1'b1;
    req0_a = 32'h0000_00FF;
    req0_b = 32'h0000_0001;
    req0_cin = 1'b0;
    req0_valid = 1'b1;
    #1;
    checks++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      errors++;
      $display("FAIL single_ready got %b%b want 10",
               req0_ready, req1_ready);
    end
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    lat = 0;
    while (!resp_valid && lat < 20) begin
      tick();
      lat++;
    end
    checks++;
    if (lat !== WORDS) begin
      errors++;
      $display("FAIL single_latency got %0d want %0d", lat, WORDS);
    end
    checks++;
    if ({resp_cout, resp_sum, resp_id} !== {1'b0, 32'h0000_0100, 1'b0}) begin
      errors++;
      $display("FAIL single_result got c%b %h id%b want c0 00000100 id0",
               resp_cout, resp_sum, resp_id);
    end
    tick();
    checks++;
    if ({busy, resp_valid} !== 2'b00) begin
      errors++;
      $display("FAIL single_release got busy%b v%b want 00",
               busy, resp_valid);
    end
  endtask

  task automatic test_ripple();
    bit ok;
    req1_a = 32'hFFFF_FFFF;
    req1_b = 32'h0000_0000;
    req1_cin = 1'b1;
    req1_valid = 1'b1;
    #1;
    checks++;
    if ({req0_ready, req1_ready} !== 2'b01) begin
      errors++;
      $display("FAIL ripple_ready got %b%b want 01",
               req0_ready, req1_ready);
    end
    @(posedge clk);
    #1;
    req1_valid = 1'b0;
    wait_resp(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL ripple_timeout got no resp_valid want 1");
    end
    checks++;
    if ({resp_cout, resp_sum, resp_id} !== {1'b1, 32'h0, 1'b1}) begin
      errors++;
      $display("FAIL ripple_result got c%b %h id%b want c1 00000000 id1",
               resp_cout, resp_sum, resp_id);
    end
    tick();
  endtask

  task automatic test_contention();
    bit ok;
    bit exp_id;
    logic [W:0] exp;
    int n;
    reset = 1'b0;
    tick();
    req0_a = 32'h1000_0001;
    req0_b = 32'h0000_0002;
    req0_cin = 1'b0;
    req1_a = 32'hFFFF_0000;
    req1_b = 32'h0001_0000;
    req1_cin = 1'b1;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    resp_ready = 1'b1;
    reset = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      exp_id = i[0];
      exp = exp_id ? {1'b1, 32'h0000_0001} : {1'b0, 32'h1000_0003};
      n = 0;
      while (!(req0_ready || req1_ready) && n < 20) begin
        tick();
        n++;
      end
      checks++;
      if ({req0_ready, req1_ready} !== {~exp_id, exp_id}) begin
        errors++;
        $display("FAIL contention_grant%0d got %b%b want %b%b",
                 i, req0_ready, req1_ready, ~exp_id, exp_id);
      end
      @(posedge clk);
      #1;
      wait_resp(ok);
      checks++;
      if (!ok || resp_id !== exp_id) begin
        errors++;
        $display("FAIL contention_id%0d got %b want %b",
                 i, resp_id, exp_id);
      end
      checks++;
      if ({resp_cout, resp_sum} !== exp) begin
        errors++;
        $display("FAIL contention_sum%0d got %h want %h",
                 i, {resp_cout, resp_sum}, exp);
      end
      tick();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    tick();
  endtask

  task automatic test_backpressure();
    bit ok;
    reset = 1'b0;
    tick();
    reset = 1'b1;
    resp_ready = 1'b0;
    req0_a = 32'h1234_5678;
    req0_b = 32'h1111_1111;
    req0_cin = 1'b1;
    req0_valid = 1'b1;
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    wait_resp(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL bp_timeout got no resp_valid want 1");
    end
    req1_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if ({resp_valid, busy, req0_ready, req1_ready} !== 4'b1100 ||
          {resp_cout, resp_sum, resp_id} !==
          {1'b0, 32'h2345_678A, 1'b0}) begin
        errors++;
        $display("FAIL bp_hold%0d got v%b b%b r%b%b c%b %h id%b want v1 b1 r00 c0 2345678a id0",
                 i, resp_valid, busy, req0_ready, req1_ready,
                 resp_cout, resp_sum, resp_id);
      end
    end
    req1_valid = 1'b0;
    resp_ready = 1'b1;
    tick();
    checks++;
    if ({busy, resp_valid} !== 2'b00) begin
      errors++;
      $display("FAIL bp_release got busy%b v%b want 00", busy, resp_valid);
    end
`ifdef ADDER_SCHED_PERF_EN
    checks++;
    if (op_count !== 16'd1) begin
      errors++;
      $display("FAIL bp_op_count got %0d want 1", op_count);
    end
`endif
  endtask

  task automatic test_reset_mid_run();
    bit ok;
    int seen;
    resp_ready = 1'b1;
    req0_a = 32'h0F0F_0F0F;
    req0_b = 32'h0101_0101;
    req0_cin = 1'b0;
    req0_valid = 1'b1;
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    checks++;
    if ({busy, resp_valid, req0_ready, req1_ready} !== 4'b0000) begin
      errors++;
      $display("FAIL midrst_state got b%b v%b r%b%b want 0000",
               busy, resp_valid, req0_ready, req1_ready);
    end
    reset = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (resp_valid) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL midrst_ghost got %0d resp cycles want 0", seen);
    end
    req0_a = 32'hAAAA_5555;
    req0_b = 32'h5555_AAAB;
    req0_cin = 1'b0;
    req1_a = 32'h0000_0007;
    req1_b = 32'h0000_0008;
    req1_cin = 1'b0;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    checks++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      errors++;
      $display("FAIL midrst_grant got %b%b want 10", req0_ready, req1_ready);
    end
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    wait_resp(ok);
    checks++;
    if (!ok || {resp_cout, resp_sum, resp_id} !== {1'b1, 32'h0, 1'b0}) begin
      errors++;
      $display("FAIL midrst_result got c%b %h id%b want c1 00000000 id0",
               resp_cout, resp_sum, resp_id);
    end
    tick();
  endtask

  task automatic test_random();
    logic [W:0] exp_q[$];
    bit         id_q[$];
    logic [W:0] exp;
    bit         eid;
    bit         a0;
    bit         a1;
    int raised = 0;
    int done = 0;
    int cyc = 0;
    while (done < 1000 && cyc < 40000) begin
      if (!req0_valid && raised < 1000 && $urandom_range(2) == 0) begin
        req0_valid = 1'b1;
        req0_a = $urandom;
        req0_b = $urandom;
        req0_cin = 1'($urandom_range(1));
        raised++;
      end
      if (!req1_valid && raised < 1000 && $urandom_range(2) == 0) begin
        req1_valid = 1'b1;
        req1_a = $urandom;
        req1_b = $urandom;
        req1_cin = 1'($urandom_range(1));
        raised++;
      end
      resp_ready = ($urandom_range(3) != 0);
      #1;
      checks++;
      if (req0_ready && req1_ready) begin
        errors++;
        $display("FAIL rand_both_ready got 11 want at most one at cycle %0d",
                 cyc);
      end
      a0 = req0_valid && req0_ready;
      a1 = req1_valid && req1_ready;
      if (a0) begin
        exp_q.push_back({1'b0, req0_a} + {1'b0, req0_b} + {32'h0, req0_cin});
        id_q.push_back(1'b0);
      end
      if (a1) begin
        exp_q.push_back({1'b0, req1_a} + {1'b0, req1_b} + {32'h0, req1_cin});
        id_q.push_back(1'b1);
      end
      if (resp_valid && resp_ready) begin
        checks++;
        done++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL rand_extra_resp got %h want none", resp_sum);
        end else begin
          exp = exp_q.pop_front();
          eid = id_q.pop_front();
          if ({resp_cout, resp_sum} !== exp || resp_id !== eid) begin
            errors++;
            $display("FAIL rand_resp%0d got %h id%b want %h id%b",
                     done, {resp_cout, resp_sum}, resp_id, exp, eid);
          end
        end
      end
      @(posedge clk);
      #1;
      cyc++;
      if (a0) req0_valid = 1'b0;
      if (a1) req1_valid = 1'b0;
    end
    checks++;
    if (done !== 1000 || exp_q.size() !== 0) begin
      errors++;
      $display("FAIL rand_count got %0d done %0d pending want 1000 0",
               done, exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_ripple();
    test_contention();
    test_backpressure();
    test_reset_mid_run();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
